// File: rtl/tanh_series_ctrl.sv
// -----------------------------------------------------------------------------
// tanh_series_ctrl
//
// Purpose:
//   Control-only sequencer for the tanh(x) series datapath. On a start request
//   it loads x, squares it, then walks the coefficient ROM address through
//   NTERMS terms. Each term takes two cycles:
//     - MUL:  term <= term * x2 * rom_data
//     - ACC:  acc  <= acc -/+ term
//   The accumulate direction alternates, starting with subtract for term 0.
//   The block finishes with a one-cycle done pulse. It holds no data; the ROM
//   and arithmetic live in the datapath.
//
// Optional build macro:
//   TANH_CTRL_EARLY_EXIT_EN
//     When defined, a big_x flag seen in LOAD makes the block skip straight to
//     DONE with sat_sel=1. When undefined, big_x is ignored and sat_sel stays 0.
//
// Parameters:
//   NTERMS : series terms after the linear term, legal range 1..8.
//   AW     : ROM address width, with 2**AW >= NTERMS.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   evaluation request, sampled only in IDLE
//   big_x    in   |x| above saturation threshold (early-exit build only)
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//   ld_x     out  datapath load x / term / acc
//   sq_en    out  datapath x2 <= x*x
//   mul_en   out  datapath term <= term*x2*rom_data
//   acc_en   out  datapath acc <= acc +/- term
//   acc_sub  out  1 = subtract term (valid with acc_en)
//   sat_sel  out  select saturated +/-1 output (valid with done)
//   rom_addr out  coefficient ROM address (cnt in MUL/ACC, else 0)
// -----------------------------------------------------------------------------
module tanh_series_ctrl #(
  parameter int NTERMS = 8,
  parameter int AW     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          big_x,
  output logic          busy,
  output logic          done,
  output logic          ld_x,
  output logic          sq_en,
  output logic          mul_en,
  output logic          acc_en,
  output logic          acc_sub,
  output logic          sat_sel,
  output logic [AW-1:0] rom_addr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SQ   = 3'd2,
    S_MUL  = 3'd3,
    S_ACC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

`ifdef TANH_CTRL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [AW-1:0] LAST_TERM = AW'(NTERMS - 1);

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_sat_flag;

  // In the default build this is constant 0, so the saturation path folds away.
  logic w_early_exit;
  assign w_early_exit = EARLY_EXIT & big_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sat_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt      <= '0;
          r_sat_flag <= 1'b0;
          if (start) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_early_exit) begin
            r_sat_flag <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_state <= S_SQ;
          end
        end
        S_SQ: begin
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_state <= S_ACC;
        end
        S_ACC: begin
          // The counter stops at the last term; it is cleared again only in IDLE.
          if (r_cnt == LAST_TERM) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_MUL;
          end
        end
        S_DONE: begin
          // A start seen here is dropped; it must still be high in IDLE.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode from the registered state. Reset forces the state to IDLE
  // asynchronously, so every output drops without waiting for a clock edge.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    ld_x     = 1'b0;
    sq_en    = 1'b0;
    mul_en   = 1'b0;
    acc_en   = 1'b0;
    acc_sub  = 1'b0;
    sat_sel  = 1'b0;
    rom_addr = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        busy = 1'b1;
        ld_x = 1'b1;
      end
      S_SQ: begin
        busy  = 1'b1;
        sq_en = 1'b1;
      end
      S_MUL: begin
        busy     = 1'b1;
        mul_en   = 1'b1;
        rom_addr = r_cnt;
      end
      S_ACC: begin
        busy     = 1'b1;
        acc_en   = 1'b1;
        rom_addr = r_cnt;
        // Even terms subtract and odd terms add: x - x^3/3 + 2x^5/15 - ...
        acc_sub  = ~r_cnt[0];
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        sat_sel = r_sat_flag;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
